// File: rtl/uart_pkg.sv
// Shared definitions for the AXI-Stream UART: parity mode codes, the
// transmit FSM state encoding and the frame data width.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_ODD   = 3'b001;
  localparam logic [2:0] PAR_EVEN  = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Codes 101..111 fall through to "no parity bit".
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN) ||
           (mode == PAR_MARK) || (mode == PAR_SPACE);
  endfunction

  // Even parity is the plain XOR of the byte; odd inverts it so the total
  // count of ones (data plus parity) comes out odd.
  function automatic logic parity_value(input logic [DATA_BITS-1:0] data,
                                        input logic [2:0] mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^data);
      PAR_EVEN: p = ^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter. Only instantiated when
// UART_TX_FIFO_EN is defined. DEPTH must be a power of two so the pointers
// wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle; a simultaneous push and pop leaves it alone.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + COUNT_ONE;
    end else if (do_pop && !do_push) begin
      count_next = count - COUNT_ONE;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and a registered full flag so TXF never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: accepts bytes on an AXI-Stream slave and serialises
// them as start / 8 data (LSB first) / optional parity / 1-2 stop bits.
// Define UART_TX_FIFO_EN to buffer bytes in a FIFO of FIFO_DEPTH entries;
// otherwise a single holding register sits in front of the shifter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 S_AXIS_ACLK,
  input  logic                 S_AXIS_ARESET,
  input  logic [DATA_BITS-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic [15:0]          PR_DIV,
  input  logic                 STOP_BITS,
  input  logic [2:0]           PARITY,
  output logic                 TX,
  output logic                 TXB,
  output logic                 TXF
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] buf_data;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_busy;
  logic                 push;
  logic                 pop;

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [15:0]          div_lat;
  logic [15:0]          bit_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_cnt;
  logic                 two_stop;
  logic                 par_en;
  logic                 par_bit;
  logic                 bit_done;
  logic                 stop_last;
  logic                 line;

  assign push          = S_AXIS_TVALID && !buf_full;
  assign S_AXIS_TREADY = !TXF;
  assign TXF           = buf_full;

`ifdef UART_TX_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (S_AXIS_ACLK),
    .reset (S_AXIS_ARESET),
    .push  (push),
    .pop   (pop),
    .wdata (S_AXIS_TDATA),
    .rdata (buf_data),
    .full  (buf_full),
    .empty (buf_empty),
    .count (fifo_count)
  );

  assign buf_busy = (fifo_count != '0);
`else
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;

  // Single-entry holding register; push and pop are mutually exclusive
  // because a push needs it empty and a pop needs it full.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_data <= S_AXIS_TDATA;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  assign buf_data  = hold_data;
  assign buf_empty = !hold_full;
  assign buf_full  = hold_full;
  assign buf_busy  = hold_full;
`endif

  assign bit_done  = (bit_cnt == div_lat);
  assign stop_last = (stop_cnt == two_stop);

  // A byte leaves the buffer from IDLE, or on the final stop cycle so the
  // next start bit follows without an idle gap.
  assign pop = !buf_empty &&
               ((state == ST_IDLE) ||
                ((state == ST_STOP) && bit_done && stop_last));

  // Frame sequencer: latches configuration with each byte and walks the bits.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      div_lat   <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      two_stop  <= 1'b0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
    end else if (pop) begin
      state     <= ST_START;
      shift_reg <= buf_data;
      div_lat   <= PR_DIV;
      two_stop  <= STOP_BITS;
      par_en    <= parity_enabled(PARITY);
      par_bit   <= parity_value(buf_data, PARITY);
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
        end
        ST_START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_cnt   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
              stop_cnt <= 1'b0;
              state    <= par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (stop_last) begin
              state <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Line level implied by the current state, before the output register.
  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shift_reg[0];
      ST_PARITY: line = par_bit;
      default:   line = 1'b1;
    endcase
  end

  // Output register: TX and TXB both trail the FSM by one clock, so TXB
  // drops exactly when the last stop bit on the wire has finished.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      TX  <= 1'b1;
      TXB <= 1'b0;
    end else begin
      TX  <= line;
      TXB <= (state != ST_IDLE) || buf_busy;
    end
  end

endmodule
